// File: rtl/riscv_axi_mux_n.sv
// riscv_axi_mux_n
//   N-port AXI4 master multiplexer. It merges the per-cache AXI master ports
//   (icache, dcache, extra cores/DMA) into one downstream AXI4 master port
//   that goes to the SoC interconnect.
//   - AR: combinational round-robin grant. The grant is held while the
//     downstream AR is stalled.
//   - AW/W: a two-state FSM locks onto one port for a whole write burst.
//   - Every downstream ID carries the source port index in its top bits.
//     R/B responses are routed back to that port.
//   - Reads and writes each have their own limit on outstanding
//     transactions (MAX_OUT).
// Ports (per-port buses are flattened; port k sits at [k*W +: W]):
//   clk_i, rst_i                      clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*/s_ar*/s_r*        upstream slave-side channels, N_PORTS wide
//   m_aw*/m_w*/m_b*/m_ar*/m_r*        downstream master-side channels,
//                                     IDs are IDX_W+ID_W bits wide
module riscv_axi_mux_n #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = 1,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // upstream AW
  input  logic [N_PORTS-1:0]         s_awvalid_i,
  output logic [N_PORTS-1:0]         s_awready_o,
  input  logic [N_PORTS*32-1:0]      s_awaddr_i,
  input  logic [N_PORTS*ID_W-1:0]    s_awid_i,
  input  logic [N_PORTS*8-1:0]       s_awlen_i,
  input  logic [N_PORTS*2-1:0]       s_awburst_i,
  // upstream W
  input  logic [N_PORTS-1:0]         s_wvalid_i,
  output logic [N_PORTS-1:0]         s_wready_o,
  input  logic [N_PORTS*32-1:0]      s_wdata_i,
  input  logic [N_PORTS*4-1:0]       s_wstrb_i,
  input  logic [N_PORTS-1:0]         s_wlast_i,
  // upstream B
  output logic [N_PORTS-1:0]         s_bvalid_o,
  input  logic [N_PORTS-1:0]         s_bready_i,
  output logic [N_PORTS*2-1:0]       s_bresp_o,
  output logic [N_PORTS*ID_W-1:0]    s_bid_o,
  // upstream AR
  input  logic [N_PORTS-1:0]         s_arvalid_i,
  output logic [N_PORTS-1:0]         s_arready_o,
  input  logic [N_PORTS*32-1:0]      s_araddr_i,
  input  logic [N_PORTS*ID_W-1:0]    s_arid_i,
  input  logic [N_PORTS*8-1:0]       s_arlen_i,
  input  logic [N_PORTS*2-1:0]       s_arburst_i,
  // upstream R
  output logic [N_PORTS-1:0]         s_rvalid_o,
  input  logic [N_PORTS-1:0]         s_rready_i,
  output logic [N_PORTS*32-1:0]      s_rdata_o,
  output logic [N_PORTS*2-1:0]       s_rresp_o,
  output logic [N_PORTS*ID_W-1:0]    s_rid_o,
  output logic [N_PORTS-1:0]         s_rlast_o,
  // downstream AW
  output logic                       m_awvalid_o,
  input  logic                       m_awready_i,
  output logic [31:0]                m_awaddr_o,
  output logic [IDX_W+ID_W-1:0]      m_awid_o,
  output logic [7:0]                 m_awlen_o,
  output logic [1:0]                 m_awburst_o,
  // downstream W
  output logic                       m_wvalid_o,
  input  logic                       m_wready_i,
  output logic [31:0]                m_wdata_o,
  output logic [3:0]                 m_wstrb_o,
  output logic                       m_wlast_o,
  // downstream B
  input  logic                       m_bvalid_i,
  output logic                       m_bready_o,
  input  logic [1:0]                 m_bresp_i,
  input  logic [IDX_W+ID_W-1:0]      m_bid_i,
  // downstream AR
  output logic                       m_arvalid_o,
  input  logic                       m_arready_i,
  output logic [31:0]                m_araddr_o,
  output logic [IDX_W+ID_W-1:0]      m_arid_o,
  output logic [7:0]                 m_arlen_o,
  output logic [1:0]                 m_arburst_o,
  // downstream R
  input  logic                       m_rvalid_i,
  output logic                       m_rready_o,
  input  logic [31:0]                m_rdata_i,
  input  logic [1:0]                 m_rresp_i,
  input  logic [IDX_W+ID_W-1:0]      m_rid_i,
  input  logic                       m_rlast_i
);

  localparam int                 MID_W    = IDX_W + ID_W;
  localparam int                 CNT_W    = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PORTS - 1);
  localparam logic [IDX_W:0]     N_IDX    = (IDX_W+1)'(N_PORTS);

  typedef enum logic [0:0] {W_IDLE, W_BURST} wstate_e;

  // Returns {found, index}: the first requester at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_PORTS-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    int unsigned      p;
    found = 1'b0;
    idx   = ptr;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      p = 32'(ptr) + i;
      if (p >= N_PORTS) p = p - N_PORTS;
      cand = IDX_W'(p);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    return (g == LAST_IDX) ? '0 : g + IDX_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // AR path
  // ---------------------------------------------------------------------
  logic             ar_hold_q;
  logic [IDX_W-1:0] ar_gnt_q;
  logic [IDX_W-1:0] rd_rr_q;
  logic [CNT_W-1:0] rd_cnt_q;

  logic [IDX_W:0]   ar_pick;
  logic             ar_active;
  logic [IDX_W-1:0] ar_gnt;
  logic             ar_hs;
  logic             rd_dec;

  always_comb begin
    ar_pick     = rr_pick(s_arvalid_i, rd_rr_q);
    ar_active   = 1'b0;
    ar_gnt      = rd_rr_q;
    s_arready_o = '0;
    if (ar_hold_q) begin
      ar_active = 1'b1;
      ar_gnt    = ar_gnt_q;
    end else if (rd_cnt_q < MAX_CNT) begin
      ar_active = ar_pick[IDX_W];
      ar_gnt    = ar_pick[IDX_W-1:0];
    end
    m_arvalid_o = ar_active && s_arvalid_i[ar_gnt] && !rst_i;
    if (ar_active && !rst_i) s_arready_o[ar_gnt] = m_arready_i;
    ar_hs = m_arvalid_o && m_arready_i;
  end

  assign m_araddr_o  = s_araddr_i[ar_gnt*32 +: 32];
  assign m_arid_o    = {ar_gnt, s_arid_i[ar_gnt*ID_W +: ID_W]};
  assign m_arlen_o   = s_arlen_i[ar_gnt*8 +: 8];
  assign m_arburst_o = s_arburst_i[ar_gnt*2 +: 2];

  // A stalled AR freezes its grant so the downstream payload stays stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_hold_q <= 1'b0;
      ar_gnt_q  <= '0;
      rd_rr_q   <= '0;
    end else if (ar_hs) begin
      ar_hold_q <= 1'b0;
      rd_rr_q   <= rr_next(ar_gnt);
    end else if (m_arvalid_o) begin
      ar_hold_q <= 1'b1;
      ar_gnt_q  <= ar_gnt;
    end
  end

  assign rd_dec = m_rvalid_i && m_rready_o && m_rlast_i && (rd_cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
    end else begin
      case ({ar_hs, rd_dec})
        2'b10:   rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        2'b01:   rd_cnt_q <= rd_cnt_q - CNT_W'(1);
        default: rd_cnt_q <= rd_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Write path FSM
  // ---------------------------------------------------------------------
  wstate_e          state_q, state_d;
  logic [IDX_W-1:0] wgnt_q, wgnt_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [IDX_W-1:0] wr_rr_q, wr_rr_d;
  logic [CNT_W-1:0] wr_cnt_q;

  logic [IDX_W:0]   aw_pick;
  logic             aw_hs;
  logic             wl_hs;
  logic             wr_dec;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= W_IDLE;
      wgnt_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_rr_q   <= '0;
    end else begin
      state_q   <= state_d;
      wgnt_q    <= wgnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_rr_q   <= wr_rr_d;
    end
  end

  // next state
  always_comb begin
    aw_pick   = rr_pick(s_awvalid_i, wr_rr_q);
    state_d   = state_q;
    wgnt_d    = wgnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_rr_d   = wr_rr_q;
    case (state_q)
      W_IDLE: begin
        if (aw_pick[IDX_W] && (wr_cnt_q < MAX_CNT)) begin
          state_d   = W_BURST;
          wgnt_d    = aw_pick[IDX_W-1:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_BURST: begin
        // AW and the last W beat may complete in either order or together.
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || wl_hs;
        if (aw_done_d && w_done_d) begin
          state_d = W_IDLE;
          wr_rr_d = rr_next(wgnt_q);
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    s_awready_o = '0;
    s_wready_o  = '0;
    if (state_q == W_BURST && !rst_i) begin
      m_awvalid_o         = s_awvalid_i[wgnt_q] && !aw_done_q;
      s_awready_o[wgnt_q] = m_awready_i && !aw_done_q;
      m_wvalid_o          = s_wvalid_i[wgnt_q] && !w_done_q;
      s_wready_o[wgnt_q]  = m_wready_i && !w_done_q;
    end
    aw_hs = m_awvalid_o && m_awready_i;
    wl_hs = m_wvalid_o && m_wready_i && m_wlast_o;
  end

  assign m_awaddr_o  = s_awaddr_i[wgnt_q*32 +: 32];
  assign m_awid_o    = {wgnt_q, s_awid_i[wgnt_q*ID_W +: ID_W]};
  assign m_awlen_o   = s_awlen_i[wgnt_q*8 +: 8];
  assign m_awburst_o = s_awburst_i[wgnt_q*2 +: 2];
  assign m_wdata_o   = s_wdata_i[wgnt_q*32 +: 32];
  assign m_wstrb_o   = s_wstrb_i[wgnt_q*4 +: 4];
  assign m_wlast_o   = s_wlast_i[wgnt_q];

  assign wr_dec = m_bvalid_i && m_bready_o && (wr_cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
    end else begin
      case ({aw_hs, wr_dec})
        2'b10:   wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        2'b01:   wr_cnt_q <= wr_cnt_q - CNT_W'(1);
        default: wr_cnt_q <= wr_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Response routing. The top ID bits select the port. Indices with no
  // port behind them are accepted and dropped so the interconnect never
  // stalls.
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] b_idx;

  assign r_idx = m_rid_i[MID_W-1 -: IDX_W];
  assign b_idx = m_bid_i[MID_W-1 -: IDX_W];

  always_comb begin
    s_rvalid_o = '0;
    m_rready_o = 1'b0;
    if (!rst_i) begin
      if ({1'b0, r_idx} < N_IDX) begin
        s_rvalid_o[r_idx] = m_rvalid_i;
        m_rready_o        = s_rready_i[r_idx];
      end else begin
        m_rready_o = 1'b1;
      end
    end
  end

  always_comb begin
    s_bvalid_o = '0;
    m_bready_o = 1'b0;
    if (!rst_i) begin
      if ({1'b0, b_idx} < N_IDX) begin
        s_bvalid_o[b_idx] = m_bvalid_i;
        m_bready_o        = s_bready_i[b_idx];
      end else begin
        m_bready_o = 1'b1;
      end
    end
  end

  assign s_rdata_o = {N_PORTS{m_rdata_i}};
  assign s_rresp_o = {N_PORTS{m_rresp_i}};
  assign s_rid_o   = {N_PORTS{m_rid_i[ID_W-1:0]}};
  assign s_rlast_o = {N_PORTS{m_rlast_i}};
  assign s_bresp_o = {N_PORTS{m_bresp_i}};
  assign s_bid_o   = {N_PORTS{m_bid_i[ID_W-1:0]}};

endmodule
